// File: rtl/fft8_pkg.sv
// Shared definitions for the 8-point radix-2 DIT FFT sequencer: sizes, FSM states,
// writeback pipeline entry and the bit-reverse helper.
package fft8_pkg;

   localparam int unsigned N     = 8;
   localparam int unsigned LOG2N = 3;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_ISSUE,
      S_WAIT,
      S_DRAIN
   } state_t;

   typedef struct packed {
      logic             vld;
      logic [LOG2N-1:0] a;
      logic [LOG2N-1:0] b;
   } wb_t;

   function automatic logic [LOG2N-1:0] bitrev3(input logic [LOG2N-1:0] x);
      return {x[0], x[1], x[2]};
   endfunction

endpackage

// File: rtl/fft8_addr_gen.sv
// Butterfly address generator: maps (stage, butterfly index) to the operand pair
// and twiddle exponent of an in-place 8-point DIT FFT.
module fft8_addr_gen
   import fft8_pkg::*;
(
   input  logic [1:0]       stage,
   input  logic [1:0]       k,
   output logic [LOG2N-1:0] a,
   output logic [LOG2N-1:0] b,
   output logic [1:0]       tw
);

   logic [LOG2N-1:0] span;
   logic [LOG2N-1:0] grp;
   logic [LOG2N-1:0] pos;

   always_comb begin
      span = LOG2N'(1) << stage;
      grp  = LOG2N'(k) >> stage;
      pos  = LOG2N'(k) & (span - LOG2N'(1));
      a    = ((grp << stage) << 1) + pos;
      b    = a + span;
      tw   = 2'(pos << (2'd2 - stage));
   end

endmodule

// File: rtl/fft8_sequencer.sv
// Control sequencer for an 8-point FFT: loads samples bit-reversed, runs 3x4 butterflies
// through one shared unit with a stage hazard guard, then drains results in natural order.
module fft8_sequencer
   import fft8_pkg::*;
#(
   parameter int unsigned BF_LAT = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             busy,
   output logic             done,
   input  logic             ld_valid,
   output logic             ld_ready,
   output logic             ld_wr_en,
   output logic [LOG2N-1:0] ld_wr_addr,
   output logic             bf_issue,
   output logic [LOG2N-1:0] bf_addr_a,
   output logic [LOG2N-1:0] bf_addr_b,
   output logic [1:0]       bf_tw_idx,
   output logic             bf_wb_en,
   output logic [LOG2N-1:0] bf_wb_addr_a,
   output logic [LOG2N-1:0] bf_wb_addr_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [LOG2N-1:0] out_rd_addr,
   output logic             out_last
);

   localparam int unsigned CNT_W  = LOG2N;
   localparam int unsigned WAIT_W = 4;

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic [1:0]        stage;
   logic [1:0]        bf;
   logic [WAIT_W-1:0] wait_cnt;
   wb_t               wb_q [BF_LAT];

   logic [LOG2N-1:0]  ag_a;
   logic [LOG2N-1:0]  ag_b;
   logic [1:0]        ag_tw;

   fft8_addr_gen u_addr_gen (
      .stage (stage),
      .k     (bf),
      .a     (ag_a),
      .b     (ag_b),
      .tw    (ag_tw)
   );

   // Output decode; everything is gated by state so idle outputs read as zero.
   assign busy         = (state != S_IDLE);
   assign ld_ready     = (state == S_LOAD);
   assign ld_wr_en     = ld_valid & ld_ready;
   assign ld_wr_addr   = ld_ready ? bitrev3(cnt) : '0;
   assign bf_issue     = (state == S_ISSUE);
   assign bf_addr_a    = bf_issue ? ag_a : '0;
   assign bf_addr_b    = bf_issue ? ag_b : '0;
   assign bf_tw_idx    = bf_issue ? ag_tw : '0;
   assign bf_wb_en     = wb_q[BF_LAT-1].vld;
   assign bf_wb_addr_a = wb_q[BF_LAT-1].a;
   assign bf_wb_addr_b = wb_q[BF_LAT-1].b;
   assign out_valid    = (state == S_DRAIN);
   assign out_rd_addr  = out_valid ? cnt : '0;
   assign out_last     = out_valid & (cnt == CNT_W'(N-1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         cnt      <= '0;
         stage    <= '0;
         bf       <= '0;
         wait_cnt <= '0;
         done     <= 1'b0;
         for (int i = 0; i < int'(BF_LAT); i++) wb_q[i] <= '0;
      end else begin
         done <= 1'b0;

         // Writeback pipe mirrors the butterfly latency so results land on the right words.
         wb_q[0].vld <= bf_issue;
         wb_q[0].a   <= bf_addr_a;
         wb_q[0].b   <= bf_addr_b;
         for (int i = 1; i < int'(BF_LAT); i++) wb_q[i] <= wb_q[i-1];

         unique case (state)
            S_IDLE: begin
               if (start) begin
                  state <= S_LOAD;
                  cnt   <= '0;
               end
            end
            S_LOAD: begin
               if (ld_valid) begin
                  cnt <= cnt + CNT_W'(1);
                  if (cnt == CNT_W'(N-1)) begin
                     state <= S_ISSUE;
                     stage <= '0;
                     bf    <= '0;
                  end
               end
            end
            S_ISSUE: begin
               bf <= bf + 2'd1;
               if (bf == 2'd3) begin
                  state    <= S_WAIT;
                  wait_cnt <= '0;
               end
            end
            // Hold off the next stage until the last writeback of this one has landed.
            S_WAIT: begin
               wait_cnt <= wait_cnt + WAIT_W'(1);
               if (wait_cnt == WAIT_W'(BF_LAT-1)) begin
                  if (stage == 2'd2) begin
                     state <= S_DRAIN;
                     cnt   <= '0;
                  end else begin
                     state <= S_ISSUE;
                     stage <= stage + 2'd1;
                     bf    <= '0;
                  end
               end
            end
            S_DRAIN: begin
               if (out_ready) begin
                  cnt <= cnt + CNT_W'(1);
                  if (cnt == CNT_W'(N-1)) begin
                     state <= S_IDLE;
                     done  <= 1'b1;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fft8_sequencer.sv
// Directed bench for fft8_sequencer: three instances (BF_LAT 1, 2, 4) share stimulus;
// instance 1 (BF_LAT=2) carries the load/issue/drain tables.
module tb_fft8_sequencer;
   import fft8_pkg::*;

   logic clk = 1'b0;
   logic rst, start, start_extra, ld_valid, out_ready;

   logic [2:0] busy_v, done_v, ld_ready_v, ld_wr_en_v, bf_issue_v, bf_wb_en_v, out_valid_v, out_last_v;
   logic [2:0] ld_wr_addr_v [3];
   logic [2:0] bf_addr_a_v [3];
   logic [2:0] bf_addr_b_v [3];
   logic [1:0] bf_tw_idx_v [3];
   logic [2:0] bf_wb_addr_a_v [3];
   logic [2:0] bf_wb_addr_b_v [3];
   logic [2:0] out_rd_addr_v [3];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int unsigned LAT = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
      fft8_sequencer #(.BF_LAT(LAT)) u_dut (
         .clk          (clk),
         .rst          (rst),
         .start        (start | (start_extra & (g == 1))),
         .busy         (busy_v[g]),
         .done         (done_v[g]),
         .ld_valid     (ld_valid),
         .ld_ready     (ld_ready_v[g]),
         .ld_wr_en     (ld_wr_en_v[g]),
         .ld_wr_addr   (ld_wr_addr_v[g]),
         .bf_issue     (bf_issue_v[g]),
         .bf_addr_a    (bf_addr_a_v[g]),
         .bf_addr_b    (bf_addr_b_v[g]),
         .bf_tw_idx    (bf_tw_idx_v[g]),
         .bf_wb_en     (bf_wb_en_v[g]),
         .bf_wb_addr_a (bf_wb_addr_a_v[g]),
         .bf_wb_addr_b (bf_wb_addr_b_v[g]),
         .out_valid    (out_valid_v[g]),
         .out_ready    (out_ready),
         .out_rd_addr  (out_rd_addr_v[g]),
         .out_last     (out_last_v[g])
      );
   end

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic int lat_of(input int j);
      return (j == 0) ? 1 : ((j == 1) ? 2 : 4);
   endfunction

   // Writeback / stage-gap model and event recorders, sampled on the falling edge.
   int         cyc = 0;
   logic       hv [3][8];
   logic [2:0] ha [3][8];
   logic [2:0] hb [3][8];
   int         last_iss [3];
   logic [7:0] iss_q [$];
   int         last_hs = 0;
   int         done_cnt = 0;

   initial begin
      for (int j = 0; j < 3; j++) begin
         last_iss[j] = -1;
         for (int k = 0; k < 8; k++) begin
            hv[j][k] = 1'b0; ha[j][k] = '0; hb[j][k] = '0;
         end
      end
   end

   always @(negedge clk) begin
      cyc++;
      for (int j = 0; j < 3; j++) begin
         int lat;
         lat = lat_of(j);
         chk($sformatf("wb_en[lat%0d]", lat), 32'(bf_wb_en_v[j]), 32'(hv[j][lat-1]));
         if (hv[j][lat-1]) begin
            chk($sformatf("wb_addr_a[lat%0d]", lat), 32'(bf_wb_addr_a_v[j]), 32'(ha[j][lat-1]));
            chk($sformatf("wb_addr_b[lat%0d]", lat), 32'(bf_wb_addr_b_v[j]), 32'(hb[j][lat-1]));
         end
         if (bf_issue_v[j]) begin
            if (last_iss[j] >= 0 && cyc - last_iss[j] > 1 && cyc - last_iss[j] < 20)
               chk($sformatf("stage_gap[lat%0d]", lat), cyc - last_iss[j], lat + 1);
            last_iss[j] = cyc;
         end
         if (rst) begin
            last_iss[j] = -1;
            for (int k = 0; k < 8; k++) hv[j][k] = 1'b0;
         end else begin
            for (int k = 7; k > 0; k--) begin
               hv[j][k] = hv[j][k-1]; ha[j][k] = ha[j][k-1]; hb[j][k] = hb[j][k-1];
            end
            hv[j][0] = bf_issue_v[j]; ha[j][0] = bf_addr_a_v[j]; hb[j][0] = bf_addr_b_v[j];
         end
      end
      if (bf_issue_v[1]) iss_q.push_back({bf_addr_a_v[1], bf_addr_b_v[1], 2'(bf_tw_idx_v[1])});
      if (out_last_v[1] && out_ready) last_hs++;
      if (done_v[1]) done_cnt++;
   end

   typedef struct {
      logic       valid;
      logic       exp_ready;
      logic       exp_en;
      logic [2:0] exp_addr;
      logic       exp_issue;
   } ld_vec_t;

   ld_vec_t    ld_tab [16];
   int         ld_n;
   logic [2:0] br_tab [8];
   int         exp_a [12];
   int         exp_b [12];
   int         exp_tw [12];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic fill_load(input bit gapped);
      if (!gapped) begin
         for (int i = 0; i < 8; i++) ld_tab[i] = '{1'b1, 1'b1, 1'b1, br_tab[i], 1'b0};
         ld_tab[8] = '{1'b1, 1'b0, 1'b0, 3'd0, 1'b1};
         ld_n = 9;
      end else begin
         for (int i = 0; i < 15; i++) begin
            if (i % 2 == 0) ld_tab[i] = '{1'b1, 1'b1, 1'b1, br_tab[i/2], 1'b0};
            else            ld_tab[i] = '{1'b0, 1'b1, 1'b0, br_tab[(i+1)/2], 1'b0};
         end
         ld_tab[15] = '{1'b0, 1'b0, 1'b0, 3'd0, 1'b1};
         ld_n = 16;
      end
   endtask

   // Starts a transform and applies the load table; returns in the 2nd compute cycle.
   task automatic do_load(input bit gapped);
      fill_load(gapped);
      start = 1'b1;
      @(negedge clk);
      chk("busy_at_start", 32'(busy_v[1]), 32'd0);
      chk("ready_at_start", 32'(ld_ready_v[1]), 32'd0);
      step();
      start = 1'b0;
      for (int i = 0; i < ld_n; i++) begin
         ld_valid = ld_tab[i].valid;
         @(negedge clk);
         chk($sformatf("ld_ready[%0d]", i), 32'(ld_ready_v[1]), 32'(ld_tab[i].exp_ready));
         chk($sformatf("ld_wr_en[%0d]", i), 32'(ld_wr_en_v[1]), 32'(ld_tab[i].exp_en));
         chk($sformatf("ld_wr_addr[%0d]", i), 32'(ld_wr_addr_v[1]), 32'(ld_tab[i].exp_addr));
         chk($sformatf("ld_issue[%0d]", i), 32'(bf_issue_v[1]), 32'(ld_tab[i].exp_issue));
         step();
      end
      ld_valid = 1'b0;
   endtask

   task automatic do_drain(input bit bp, input bit start_mid, input bit start_done);
      int n;
      int beats;
      int i;
      out_ready = 1'b1;
      last_hs   = 0;
      done_cnt  = 0;
      n = 0;
      @(negedge clk);
      while (!out_valid_v[1] && n < 200) begin
         step();
         n++;
         @(negedge clk);
      end
      chk("compute_len", n, 17);
      beats = 0;
      i = 0;
      while (beats < 8 && i < 64) begin
         chk($sformatf("out_valid[%0d]", i), 32'(out_valid_v[1]), 32'd1);
         chk($sformatf("out_rd_addr[%0d]", i), 32'(out_rd_addr_v[1]), beats);
         chk($sformatf("out_last[%0d]", i), 32'(out_last_v[1]), 32'(beats == 7));
         chk($sformatf("done_early[%0d]", i), 32'(done_v[1]), 32'd0);
         if (out_ready) beats++;
         step();
         i++;
         out_ready   = bp ? (i % 3 == 0) : 1'b1;
         start_extra = (start_mid && i == 2) || (start_done && beats == 8);
         @(negedge clk);
      end
      chk("drain_bound", 32'(i < 64), 32'd1);
      chk("done_pulse", 32'(done_v[1]), 32'd1);
      chk("valid_after", 32'(out_valid_v[1]), 32'd0);
      chk("busy_after", 32'(busy_v[1]), 32'd0);
      step();
      start_extra = 1'b0;
      out_ready   = 1'b1;
      @(negedge clk);
      if (start_done) begin
         chk("restart_busy", 32'(busy_v[1]), 32'd1);
         chk("restart_ready", 32'(ld_ready_v[1]), 32'd1);
      end else begin
         chk("idle_busy", 32'(busy_v[1]), 32'd0);
         chk("done_cleared", 32'(done_v[1]), 32'd0);
      end
      chk("last_handshakes", last_hs, 1);
      chk("done_pulses", done_cnt, 1);
      step();
   endtask

   task automatic chk_iss();
      chk("issue_count", iss_q.size(), 12);
      for (int i = 0; i < 12 && i < iss_q.size(); i++) begin
         chk($sformatf("issue_a[%0d]", i), 32'(iss_q[i][7:5]), exp_a[i]);
         chk($sformatf("issue_b[%0d]", i), 32'(iss_q[i][4:2]), exp_b[i]);
         chk($sformatf("issue_tw[%0d]", i), 32'(iss_q[i][1:0]), exp_tw[i]);
      end
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      @(negedge clk);
      while (busy_v != 3'b000 && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("idle_timeout", 32'(n < 300), 32'd1);
      step();
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; start_extra = 1'b0; ld_valid = 1'b1; out_ready = 1'b0;
      br_tab = '{3'd0, 3'd4, 3'd2, 3'd6, 3'd1, 3'd5, 3'd3, 3'd7};
      exp_a  = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
      exp_b  = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
      exp_tw = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

      step();
      step();
      @(negedge clk);
      chk("rst_busy", 32'(busy_v), 32'd0);
      chk("rst_done", 32'(done_v), 32'd0);
      chk("rst_ld_ready", 32'(ld_ready_v[1]), 32'd0);
      chk("rst_ld_wr_en", 32'(ld_wr_en_v[1]), 32'd0);
      chk("rst_ld_wr_addr", 32'(ld_wr_addr_v[1]), 32'd0);
      chk("rst_bf_issue", 32'(bf_issue_v[1]), 32'd0);
      chk("rst_bf_addr_a", 32'(bf_addr_a_v[1]), 32'd0);
      chk("rst_bf_addr_b", 32'(bf_addr_b_v[1]), 32'd0);
      chk("rst_bf_tw", 32'(bf_tw_idx_v[1]), 32'd0);
      chk("rst_wb_en", 32'(bf_wb_en_v), 32'd0);
      chk("rst_wb_addr", 32'({bf_wb_addr_a_v[1], bf_wb_addr_b_v[1]}), 32'd0);
      chk("rst_out_valid", 32'(out_valid_v[1]), 32'd0);
      chk("rst_out_rd_addr", 32'(out_rd_addr_v[1]), 32'd0);
      chk("rst_out_last", 32'(out_last_v[1]), 32'd0);
      step();
      rst = 1'b0;
      ld_valid = 1'b0;
      out_ready = 1'b1;
      step();

      // Back-to-back load, free-flowing drain.
      iss_q.delete();
      do_load(1'b0);
      do_drain(1'b0, 1'b0, 1'b0);
      chk_iss();
      wait_idle();

      // 50% gapped load, 1-0-0 backpressure, start pulse during drain.
      iss_q.delete();
      do_load(1'b1);
      do_drain(1'b1, 1'b1, 1'b0);
      chk_iss();
      wait_idle();

      // Reset while stage 1 butterfly 2 is issuing.
      do_load(1'b0);
      repeat (7) step();
      rst = 1'b1;
      @(negedge clk);
      chk("pre_rst_issue", 32'(bf_issue_v[1]), 32'd1);
      chk("pre_rst_addr_a", 32'(bf_addr_a_v[1]), 32'd4);
      chk("pre_rst_addr_b", 32'(bf_addr_b_v[1]), 32'd6);
      chk("pre_rst_tw", 32'(bf_tw_idx_v[1]), 32'd0);
      step();
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_busy", 32'(busy_v), 32'd0);
      for (int k = 0; k < 6; k++) begin
         chk($sformatf("post_rst_wb[%0d]", k), 32'(bf_wb_en_v), 32'd0);
         @(negedge clk);
      end
      step();

      // Fresh full run; start coincident with done is accepted.
      iss_q.delete();
      do_load(1'b0);
      do_drain(1'b0, 1'b0, 1'b1);
      chk_iss();
      rst = 1'b1;
      step();
      rst = 1'b0;
      wait_idle();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
